fft_out_formatter: RTL and testbench
====================================

# fft_out_formatter

Output formatter between the last FFT butterfly stage and the output FIFOs. It accepts full-width stage results as a valid-only stream with no backpressure. Each result is rounded and saturated to DATA_WIDTH, tagged with its bin index and frame markers, and buffered so the downstream consumer can apply valid/ready backpressure. This replaces raw bit truncation and adds saturation and drop visibility.

## Interface
- N, 16: FFT points per frame, power of two ≥ 4
- DATA_WIDTH, 16: output sample width, signed
- INT_WIDTH, 32: input (stage) sample width, signed
- SHIFT, 0: arithmetic right-shift applied before saturation, 0..INT_WIDTH-DATA_WIDTH
- DEPTH, 32: buffer entries, power of two ≥ N
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  stage result valid; no ready exists, upstream never stalls
- in_real, in_imag  in  INT_WIDTH each  stage result, signed
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head when out_valid && out_ready
- out_real, out_imag  out  DATA_WIDTH each  formatted sample
- out_bin  out  $clog2(N)  bin index of head sample
- out_sop, out_eop  out  1  head is bin 0 / bin N-1
- sat_cnt  out  16  saturated-sample count, sticks at 0xFFFF
- drop_err  out  1  sticky: a sample arrived while the buffer was full
- clr  in  1  synchronous clear of sat_cnt and drop_err

## Operation
- Format path, per component:
  - if SHIFT>0, compute v = (x + 2^(SHIFT-1)) >>> SHIFT, round half up, in INT_WIDTH+1 bits to avoid adder wrap; if SHIFT=0, v = x
  - clamp v to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]
- A sample is saturated if either component clamps. sat_cnt increments once per saturated sample.
- Bin counter:
  - increments on every in_valid, including dropped samples, so frame alignment survives drops
  - wraps N-1 → 0
  - the current counter value is stored with the sample; sop = (bin==0), eop = (bin==N-1)
- Buffer: circular, DEPTH entries of {real, imag, bin}, write/read pointers with an extra wrap bit.
- Full handling:
  - if in_valid is seen with the buffer full and no read on the same edge, the sample is discarded, drop_err is set, and the pointer is unchanged
  - a simultaneous read while full frees the slot, so the write is accepted
- clr has priority over a same-cycle increment or set; both counters read 0 after that edge.
- Data is not reordered; input order equals output order, with natural bin order guaranteed upstream.

## Timing
- Reset values: out_valid=0, out_real/out_imag=0, out_bin=0, out_sop=0, out_eop=0, sat_cnt=0, drop_err=0, bin counter=0, pointers=0.
- Latency:
  - sample with in_valid sampled at edge k, buffer empty: out_valid=1 with that data after edge k
  - first-word-fall-through; out_* are driven from storage and the head register, with no combinational path from in_* to out_*
- out_* are stable while out_valid && !out_ready.
- Throughput: one write and one read per cycle sustained.
- Empty with a same-edge write: no read is possible that edge; the data appears the next cycle.
- Reset mid-frame: the buffer is flushed and the bin counter restarts at 0. The next in_valid is bin 0.

## Structure
- N, DATA_WIDTH, INT_WIDTH come from the shared FFT package as defaults.
- Add to the package:
  - typedef fmt_entry_t {real, imag, bin}
  - function sat_round(x, shift) returning the DATA_WIDTH result plus a saturation flag
- One sub-module: fft_fmt_buf, the circular buffer with full/empty and the simultaneous read/write rule. Formatting, bin counter and stats live in the top.

## Test plan
- SHIFT=0, in_real=100, in_imag=-3, out_ready=1 → out_real=100, out_imag=-3, out_bin=0, out_sop=1, out_valid exactly one cycle after; sat_cnt=0.
- SHIFT=0, in_real=40000, in_imag=-40000 → out_real=0x7FFF, out_imag=0x8000; sat_cnt=1. Then clr pulse → sat_cnt=0.
- SHIFT=2, inputs 7, -7, -6, 6 (real) → outputs 2, -2, -1, 2.
- 3 frames of 16 back-to-back samples, out_ready random 50% → all 48 samples out in order; bins 0..15 repeating; sop on bin 0, eop on bin 15; drop_err=0.
- out_ready=0, 33 samples with DEPTH=32 → drop_err=1, 32 entries retained. Then out_ready=1 → 32 outputs, bins 0..15,0..15; sample 33 (bin 0) absent. With full buffer plus simultaneous read+write → no drop.
- Assert rst_n low after 5 samples of a frame → out_valid=0, counters 0; the next sample emerges with out_bin=0, out_sop=1.

Source files
------------

// File: rtl/fft_out_formatter_pkg.sv
// Shared FFT output-formatting definitions: default widths, buffer entry layout
// and the round/saturate helper used on each stage-result component.
package fft_out_formatter_pkg;

    localparam int unsigned FFT_N          = 16;
    localparam int unsigned FFT_DATA_WIDTH = 16;
    localparam int unsigned FFT_INT_WIDTH  = 32;
    localparam int unsigned FFT_BIN_WIDTH  = $clog2(FFT_N);
    localparam int unsigned SAT_CNT_WIDTH  = 16;

    // One buffered output sample for the default configuration.
    typedef struct packed {
        logic signed [FFT_DATA_WIDTH-1:0] re;
        logic signed [FFT_DATA_WIDTH-1:0] im;
        logic [FFT_BIN_WIDTH-1:0]         bin;
    } fmt_entry_t;

    // Rounded/clamped value (sign-extended to 64 bits) plus clamp flag.
    typedef struct packed {
        logic signed [63:0] val;
        logic               sat;
    } sat_res_t;

    // Round half up by 'shift' bits, then clamp to a signed 'dw'-bit range.
    // Working in 64 bits keeps the rounding adder from wrapping for any
    // input width up to 62 bits.
    function automatic sat_res_t sat_round(input logic signed [63:0] x,
                                           input int unsigned shift,
                                           input int unsigned dw = FFT_DATA_WIDTH);
        sat_res_t           res;
        logic signed [63:0] v;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        v = x;
        if (shift > 0) begin
            v = (x + (64'sd1 <<< (shift - 1))) >>> shift;
        end
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        res.val = v;
        res.sat = 1'b0;
        if (v > hi) begin
            res.val = hi;
            res.sat = 1'b1;
        end else if (v < lo) begin
            res.val = lo;
            res.sat = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fft_fmt_buf.sv
// Circular first-word-fall-through buffer. Pointers carry an extra wrap bit to
// tell full from empty; a read on the same edge as a write into a full buffer
// frees the slot so the write is accepted.
module fft_fmt_buf
    import fft_out_formatter_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = $bits(fmt_entry_t)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_req,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_req,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             rd_fire;
    logic             wr_fire;

    // Occupancy flags and accepted-transfer strobes.
    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        rd_fire = rd_req && !empty;
        wr_fire = wr_req && (!full || rd_fire);
        rd_data = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers; reset flushes the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (rd_fire) begin
                rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/fft_out_formatter.sv
// FFT output formatter: rounds and saturates each stage result, tags it with
// its bin index, and buffers it so the consumer can apply backpressure.
// Tracks saturated samples and flags samples dropped on a full buffer.
module fft_out_formatter
    import fft_out_formatter_pkg::*;
#(
    parameter int unsigned N          = FFT_N,
    parameter int unsigned DATA_WIDTH = FFT_DATA_WIDTH,
    parameter int unsigned INT_WIDTH  = FFT_INT_WIDTH,
    parameter int unsigned SHIFT      = 0,
    parameter int unsigned DEPTH      = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic signed [INT_WIDTH-1:0]   in_real,
    input  logic signed [INT_WIDTH-1:0]   in_imag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [DATA_WIDTH-1:0]  out_real,
    output logic signed [DATA_WIDTH-1:0]  out_imag,
    output logic [$clog2(N)-1:0]          out_bin,
    output logic                          out_sop,
    output logic                          out_eop,
    output logic [SAT_CNT_WIDTH-1:0]      sat_cnt,
    output logic                          drop_err,
    input  logic                          clr
);

    localparam int unsigned BW = $clog2(N);

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] re;
        logic signed [DATA_WIDTH-1:0] im;
        logic [BW-1:0]                bin;
    } entry_t;

    localparam int unsigned EW = $bits(entry_t);

    sat_res_t                 fmt_re;
    sat_res_t                 fmt_im;
    entry_t                   wr_entry;
    entry_t                   head;
    logic [EW-1:0]            rd_bits;
    logic [BW-1:0]            bin_q;
    logic [SAT_CNT_WIDTH-1:0] sat_cnt_q;
    logic                     drop_err_q;
    logic                     sample_sat;
    logic                     drop;
    logic                     full;
    logic                     empty;
    logic                     unused_fmt_hi;

    // Format path: round/saturate both components and tag with the current bin.
    always_comb begin
        fmt_re          = sat_round(64'(in_real), SHIFT, DATA_WIDTH);
        fmt_im          = sat_round(64'(in_imag), SHIFT, DATA_WIDTH);
        wr_entry.re     = fmt_re.val[DATA_WIDTH-1:0];
        wr_entry.im     = fmt_im.val[DATA_WIDTH-1:0];
        wr_entry.bin    = bin_q;
        sample_sat      = in_valid && (fmt_re.sat || fmt_im.sat);
        // Write refused only when full and the head is not leaving this edge.
        drop            = in_valid && full && !(out_ready && !empty);
        unused_fmt_hi   = ^{fmt_re.val[63:DATA_WIDTH], fmt_im.val[63:DATA_WIDTH]};
    end

    // Bin counter advances on every arriving sample, dropped or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
        end else if (in_valid) begin
            bin_q <= bin_q + {{(BW-1){1'b0}}, 1'b1};
        end
    end

    // Saturation counter and sticky drop flag; clr wins over same-cycle events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q  <= '0;
            drop_err_q <= 1'b0;
        end else if (clr) begin
            sat_cnt_q  <= '0;
            drop_err_q <= 1'b0;
        end else begin
            if (sample_sat && (sat_cnt_q != '1)) begin
                sat_cnt_q <= sat_cnt_q + {{(SAT_CNT_WIDTH-1){1'b0}}, 1'b1};
            end
            if (drop) begin
                drop_err_q <= 1'b1;
            end
        end
    end

    fft_fmt_buf #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_req  (in_valid),
        .wr_data (wr_entry),
        .rd_req  (out_ready),
        .rd_data (rd_bits),
        .full    (full),
        .empty   (empty)
    );

    // Head presentation; fields read as zero while nothing is buffered.
    always_comb begin
        head      = entry_t'(rd_bits);
        out_valid = !empty;
        out_real  = out_valid ? head.re : '0;
        out_imag  = out_valid ? head.im : '0;
        out_bin   = out_valid ? head.bin : '0;
        out_sop   = out_valid && (head.bin == '0);
        out_eop   = out_valid && (head.bin == BW'(N - 1));
        sat_cnt   = sat_cnt_q;
        drop_err  = drop_err_q;
    end

endmodule

// File: tb/tb_fft_out_formatter.sv
// Directed bench for fft_out_formatter: format vectors, clr, mid-frame reset,
// back-to-back frames under backpressure, and overflow handling.
module tb_fft_out_formatter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               clr;
    logic               in_valid;
    logic signed [31:0] in_real;
    logic signed [31:0] in_imag;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_real;
    logic signed [15:0] out_imag;
    logic [3:0]         out_bin;
    logic               out_sop;
    logic               out_eop;
    logic [15:0]        sat_cnt;
    logic               drop_err;

    logic               s2_in_valid;
    logic signed [31:0] s2_in_real;
    logic signed [31:0] s2_in_imag;
    logic               s2_out_valid;
    logic               s2_out_ready;
    logic signed [15:0] s2_out_real;
    logic signed [15:0] s2_out_imag;
    logic [3:0]         s2_out_bin;
    logic               s2_out_sop;
    logic               s2_out_eop;
    logic [15:0]        s2_sat_cnt;
    logic               s2_drop_err;

    fft_out_formatter #(.SHIFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_real(in_real),
        .in_imag(in_imag), .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_imag(out_imag), .out_bin(out_bin),
        .out_sop(out_sop), .out_eop(out_eop), .sat_cnt(sat_cnt),
        .drop_err(drop_err), .clr(clr)
    );

    fft_out_formatter #(.SHIFT(2)) dut_s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(s2_in_valid), .in_real(s2_in_real),
        .in_imag(s2_in_imag), .out_valid(s2_out_valid), .out_ready(s2_out_ready),
        .out_real(s2_out_real), .out_imag(s2_out_imag), .out_bin(s2_out_bin),
        .out_sop(s2_out_sop), .out_eop(s2_out_eop), .sat_cnt(s2_sat_cnt),
        .drop_err(s2_drop_err), .clr(clr)
    );

    typedef struct {
        bit use2;
        int re_in;
        int im_in;
        int re_exp;
        int im_exp;
        bit sat;
    } vec_t;

    typedef struct {
        int re;
        int im;
        int bin;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    vec_t vecs[9];

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;
        s2_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: score a handshake against the queue and check hold stability.
    task automatic step();
        exp_t             e;
        logic             hold_v;
        logic signed [15:0] hold_re;
        logic [3:0]       hold_bin;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_output: got real=%0d with no sample expected", out_real);
            end else begin
                e = q.pop_front();
                chk("q_real", out_real, e.re);
                chk("q_imag", out_imag, e.im);
                chk("q_bin", out_bin, e.bin);
                chk("q_sop", out_sop, e.bin == 0);
                chk("q_eop", out_eop, e.bin == 15);
            end
        end
        hold_v   = out_valid && !out_ready;
        hold_re  = out_real;
        hold_bin = out_bin;
        tick();
        if (hold_v) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_real", out_real, hold_re);
            chk("hold_bin", out_bin, hold_bin);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bin_model;
        int sat_model;
        int s2_sat_model;

        vecs[0] = '{0, 100, -3, 100, -3, 0};
        vecs[1] = '{0, 40000, -40000, 32767, -32768, 1};
        vecs[2] = '{0, 32767, -32768, 32767, -32768, 0};
        vecs[3] = '{0, 32768, 0, 32767, 0, 1};
        vecs[4] = '{0, -32769, 5, -32768, 5, 1};
        vecs[5] = '{1, 7, 131069, 2, 32767, 0};
        vecs[6] = '{1, -7, 131070, -2, 32767, 1};
        vecs[7] = '{1, -6, -131074, -1, -32768, 0};
        vecs[8] = '{1, 6, -131075, 2, -32768, 1};

        in_real = 0; in_imag = 0; s2_in_real = 0; s2_in_imag = 0;
        s2_out_ready = 1'b1;
        do_reset();

        // Reset state.
        chk("rst_valid", out_valid, 0);
        chk("rst_real", out_real, 0);
        chk("rst_imag", out_imag, 0);
        chk("rst_bin", out_bin, 0);
        chk("rst_sop", out_sop, 0);
        chk("rst_eop", out_eop, 0);
        chk("rst_sat", sat_cnt, 0);
        chk("rst_drop", drop_err, 0);
        chk("rst_s2_valid", s2_out_valid, 0);

        // Format vectors, one sample at a time.
        bin_model = 0; sat_model = 0; s2_sat_model = 0;
        for (int i = 0; i < 9; i++) begin
            if (!vecs[i].use2) begin
                chk("pre_valid", out_valid, 0);
                in_valid = 1'b1; in_real = vecs[i].re_in; in_imag = vecs[i].im_in;
                out_ready = 1'b0;
                tick();
                in_valid = 1'b0;
                if (vecs[i].sat) sat_model++;
                chk("v_valid", out_valid, 1);
                chk("v_real", out_real, vecs[i].re_exp);
                chk("v_imag", out_imag, vecs[i].im_exp);
                chk("v_bin", out_bin, bin_model);
                chk("v_sop", out_sop, bin_model == 0);
                chk("v_sat_cnt", sat_cnt, sat_model);
                bin_model = (bin_model + 1) % 16;
                out_ready = 1'b1;
                tick();
                out_ready = 1'b0;
                chk("v_drained", out_valid, 0);
            end else begin
                s2_in_valid = 1'b1;
                s2_in_real = vecs[i].re_in; s2_in_imag = vecs[i].im_in;
                tick();
                s2_in_valid = 1'b0;
                if (vecs[i].sat) s2_sat_model++;
                chk("s2_valid", s2_out_valid, 1);
                chk("s2_real", s2_out_real, vecs[i].re_exp);
                chk("s2_imag", s2_out_imag, vecs[i].im_exp);
                chk("s2_sat_cnt", s2_sat_cnt, s2_sat_model);
                tick();
                chk("s2_drained", s2_out_valid, 0);
            end
        end

        // clr beats a same-cycle saturated sample.
        clr = 1'b1; in_valid = 1'b1; in_real = 40000; in_imag = 0;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        chk("clr_sat_cnt", sat_cnt, 0);
        chk("clr_sample_real", out_real, 32767);
        chk("clr_sample_bin", out_bin, bin_model);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Mid-frame reset with a sample pending and a nonzero sat count.
        in_valid = 1'b1; in_real = -50000; in_imag = 0;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_sat", sat_cnt, 1);
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_sat", sat_cnt, 0);
        chk("mid_rst_bin", out_bin, 0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; in_real = 50; in_imag = 60;
        tick();
        in_valid = 1'b0;
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_real", out_real, 50);
        chk("post_rst_bin", out_bin, 0);
        chk("post_rst_sop", out_sop, 1);
        chk("post_rst_eop", out_eop, 0);

        // Three back-to-back frames under random backpressure.
        do_reset();
        q.delete();
        for (int c = 0; c < 400 && (c < 48 || q.size() > 0); c++) begin
            if (c < 48) begin
                in_valid = 1'b1; in_real = c; in_imag = -c;
                q.push_back('{c, -c, c % 16});
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 1) == 1) || (q.size() >= 24);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("frames_left", q.size(), 0);
        chk("frames_drop", drop_err, 0);
        chk("frames_empty", out_valid, 0);

        // Overflow: 33 writes into 32 entries, then full with read+write.
        do_reset();
        q.delete();
        for (int i = 0; i < 33; i++) begin
            in_valid = 1'b1; in_real = i; in_imag = i + 1000;
            if (i < 32) q.push_back('{i, i + 1000, i % 16});
            step();
        end
        in_valid = 1'b0;
        chk("ovf_drop_err", drop_err, 1);
        chk("ovf_valid", out_valid, 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("ovf_clr", drop_err, 0);
        in_valid = 1'b1; in_real = 500; in_imag = -500; out_ready = 1'b1;
        q.push_back('{500, -500, 1});
        step();
        in_valid = 1'b0;
        chk("full_rw_no_drop", drop_err, 0);
        for (int c = 0; c < 40 && q.size() > 0; c++) step();
        out_ready = 1'b0;
        chk("ovf_left", q.size(), 0);
        chk("ovf_empty", out_valid, 0);
        chk("ovf_drop_final", drop_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
